// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption controller, one round per clock.
// Optional macro AES_PERF_CNT_EN adds the perf_blocks / perf_stall counters.
// Handshake: a transfer on either side happens on a rising clk edge where valid and
// ready are both high; ready never depends on valid, and out_state is held until taken.

// Combinational SubBytes over a 4x32 state: GF(2^8) inverse (x^254) plus affine map.
module aes_sub_bytes (
  input  logic [3:0][31:0] din,
  output logic [3:0][31:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^(2+4+...+128); zero maps to zero naturally.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = b;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution of all sixteen state bytes.
  always_comb begin
    dout = '0;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        dout[w][8*b +: 8] = sbox(din[w][8*b +: 8]);
  end
endmodule

module aes_round_sequencer #(
  parameter int regSize = 32,
  parameter int vecSize = 4,
  parameter int NROUNDS = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [vecSize-1:0][regSize-1:0] in_state,
  output logic [3:0]                      round_idx,
  input  logic [vecSize-1:0][regSize-1:0] round_key,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [vecSize-1:0][regSize-1:0] out_state,
  output logic                            busy,
  output logic [1:0]                      dbg_state
`ifdef AES_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_blocks,
  output logic [31:0]                     perf_stall
`endif
);
  typedef logic [vecSize-1:0][regSize-1:0] state_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;

  fsm_t       fsm_q, fsm_d;
  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  state_t     sb, sr, mc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r (bits [31-8r -: 8] of every column) rotates left by r columns.
  function automatic state_t shift_rows(input state_t s);
    state_t     o;
    logic [1:0] src;
    o = s;
    for (int c = 0; c < vecSize; c++)
      for (int r = 0; r < 4; r++) begin
        src = 2'((c + r) % vecSize);
        o[c][8*(3-r) +: 8] = s[src][8*(3-r) +: 8];
      end
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t     o;
    logic [7:0] a0, a1, a2, a3;
    o = s;
    for (int c = 0; c < vecSize; c++) begin
      a0 = s[c][31:24];
      a1 = s[c][23:16];
      a2 = s[c][15:8];
      a3 = s[c][7:0];
      o[c] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  aes_sub_bytes u_sub_bytes (
    .din  (state_q),
    .dout (sb)
  );

  // Round datapath pieces shared by ROUND and FINAL.
  always_comb begin
    sr = shift_rows(sb);
    mc = mix_columns(sr);
  end

  // Next-state, round-key index and handshake outputs.
  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    round_idx = rnd_q;
    case (fsm_q)
      S_IDLE: begin
        in_ready  = 1'b1;
        round_idx = 4'd0;
        if (in_valid) begin
          state_d = in_state ^ round_key;
          rnd_d   = 4'd1;
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = mc ^ round_key;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == 4'(NROUNDS - 1)) fsm_d = S_FINAL;
      end
      S_FINAL: begin
        round_idx = 4'(NROUNDS);
        state_d   = sr ^ round_key;
        fsm_d     = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = S_IDLE;
          rnd_d = 4'd0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State, round counter and FSM registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign out_state = state_q;
  assign busy      = (fsm_q != S_IDLE);
  assign dbg_state = fsm_q;

`ifdef AES_PERF_CNT_EN
  logic [31:0] blocks_q, blocks_d, stall_q, stall_d;

  // Completed-block and output-stall counters, wrapping modulo 2^32.
  always_comb begin
    blocks_d = blocks_q + {31'd0, out_valid & out_ready};
    stall_d  = stall_q + {31'd0, (fsm_q == S_DONE) & ~out_ready};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blocks_q <= '0;
      stall_q  <= '0;
    end else begin
      blocks_q <= blocks_d;
      stall_q  <= stall_d;
    end
  end

  assign perf_blocks = blocks_q;
  assign perf_stall  = stall_q;
`endif
endmodule
